ps2_scancode_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_ascii_lut.sv | 34 +++
 rtl/ps2_scancode_decoder.sv | 111 +++++++++++
 tb/tb_ps2_scancode_decoder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 set-2 scancode decoder: prefix bytes,
// pop-handshake state encoding and a few named scan codes.
package ps2_pkg;

    localparam logic [7:0] EXT_CODE = 8'hE0;
    localparam logic [7:0] BRK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational PS/2 set-2 scan code to ASCII lookup (a-z, 0-9, space, enter).
// Extended codes and unmapped codes yield 8'h00.
module ps2_ascii_lut (
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    always_comb begin
        // NOTE: default first so every path assigns ascii and no latch is inferred.
        ascii = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: ascii = "a"; 8'h32: ascii = "b"; 8'h21: ascii = "c";
                8'h23: ascii = "d"; 8'h24: ascii = "e"; 8'h2B: ascii = "f";
                8'h34: ascii = "g"; 8'h33: ascii = "h"; 8'h43: ascii = "i";
                8'h3B: ascii = "j"; 8'h42: ascii = "k"; 8'h4B: ascii = "l";
                8'h3A: ascii = "m"; 8'h31: ascii = "n"; 8'h44: ascii = "o";
                8'h4D: ascii = "p"; 8'h15: ascii = "q"; 8'h2D: ascii = "r";
                8'h1B: ascii = "s"; 8'h2C: ascii = "t"; 8'h3C: ascii = "u";
                8'h2A: ascii = "v"; 8'h1D: ascii = "w"; 8'h22: ascii = "x";
                8'h35: ascii = "y"; 8'h1A: ascii = "z";
                8'h45: ascii = "0"; 8'h16: ascii = "1"; 8'h1E: ascii = "2";
                8'h26: ascii = "3"; 8'h25: ascii = "4"; 8'h2E: ascii = "5";
                8'h36: ascii = "6"; 8'h3D: ascii = "7"; 8'h3E: ascii = "8";
                8'h46: ascii = "9";
                8'h29: ascii = 8'h20;
                8'h5A: ascii = 8'h0D;
                default: ascii = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops bytes from the ps2_keyboard FIFO and decodes set-2 make/break/extended events.
// Define PS2_ASCII_EN to drive ascii from ps2_ascii_lut; otherwise ascii is 8'h00.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int         CNT_W      = 8,
    parameter logic [7:0] EXT_PREFIX = EXT_CODE,
    parameter logic [7:0] BRK_PREFIX = BRK_CODE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic             event_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_repeat,
    output logic             key_down,
    output logic [7:0]       cur_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_seen,
    output logic [7:0]       ascii
);

    state_t state;
    logic   ext_q;
    logic   brk_q;
    logic   held_ext;
    logic   same_key;

    assign same_key = (data == cur_code) && (ext_q == held_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            nextdata_n  <= 1'b1;
            event_valid <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_break   <= 1'b0;
            key_repeat  <= 1'b0;
            key_down    <= 1'b0;
            cur_code    <= '0;
            press_cnt   <= '0;
            ovf_seen    <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_ext    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make the strobes single-cycle unless re-asserted below.
            event_valid <= 1'b0;
            nextdata_n  <= 1'b1;
            if (overflow)
                ovf_seen <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (ready) begin
                        state      <= ST_ACK;
                        nextdata_n <= 1'b0;
                        if (data == EXT_PREFIX) begin
                            ext_q <= 1'b1;
                        end else if (data == BRK_PREFIX) begin
                            brk_q <= 1'b1;
                        end else begin
                            event_valid <= 1'b1;
                            key_code    <= data;
                            key_ext     <= ext_q;
                            key_break   <= brk_q;
                            ext_q       <= 1'b0;
                            brk_q       <= 1'b0;
                            if (!brk_q) begin
                                if (key_down && same_key) begin
                                    key_repeat <= 1'b1;
                                end else begin
                                    key_repeat <= 1'b0;
                                    press_cnt  <= press_cnt + 1'b1;
                                    cur_code   <= data;
                                    held_ext   <= ext_q;
                                    key_down   <= 1'b1;
                                end
                            end else begin
                                key_repeat <= 1'b0;
                                if (same_key)
                                    key_down <= 1'b0;
                            end
                        end
                    end
                end
                ST_ACK:  state <= ST_GAP;
                // FIFO head pointer is still settling here, so ready is ignored.
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PS2_ASCII_EN
    ps2_ascii_lut u_ascii_lut (
        .code  (key_code),
        .ext   (key_ext),
        .ascii (ascii)
    );
`else
    assign ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomized self-checking bench for ps2_scancode_decoder with a FIFO model and a
// key-state reference model evaluated per popped byte.
module tb_ps2_scancode_decoder;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       nextdata_n;
    logic       event_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_repeat;
    logic       key_down;
    logic [7:0] cur_code;
    logic [7:0] press_cnt;
    logic       ovf_seen;
    logic [7:0] ascii;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .ready       (ready),
        .overflow    (overflow),
        .nextdata_n  (nextdata_n),
        .event_valid (event_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_break   (key_break),
        .key_repeat  (key_repeat),
        .key_down    (key_down),
        .cur_code    (cur_code),
        .press_cnt   (press_cnt),
        .ovf_seen    (ovf_seen),
        .ascii       (ascii)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // FIFO contents, cycle bookkeeping
    logic [7:0] q[$];
    int cyc      = 0;
    int last_ack = -1;
    bit prev_ack = 0;

    // Reference model: pending prefixes, held key identity {ext,code}, press count
    bit pend_ext, pend_brk, m_down, m_ovf;
    int held_id;
    int m_presses;
    logic [7:0] e_code;
    bit e_ext, e_brk, e_rep;

    function automatic void model_reset();
        pend_ext  = 0; pend_brk = 0; m_down = 0; m_ovf = 0;
        held_id   = 0; m_presses = 0;
        e_code    = 8'h00; e_ext = 0; e_brk = 0; e_rep = 0;
        last_ack  = -1; prev_ack = 0;
    endfunction

    function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit x);
`ifdef PS2_ASCII_EN
        logic [7:0] codes [38] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                                   8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                                   8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A,8'h45,8'h16,8'h1E,8'h26,
                                   8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h29,8'h5A};
        if (x) return 8'h00;
        for (int i = 0; i < 38; i++) begin
            if (codes[i] == c) begin
                if (i < 26) return 8'h61 + 8'(i);
                if (i < 36) return 8'h30 + 8'(i - 26);
                return (i == 36) ? 8'h20 : 8'h0D;
            end
        end
        return 8'h00;
`else
        return (c == 8'h00 && x) ? 8'h00 : 8'h00;
`endif
    endfunction

    // Returns 1 when the byte is a key event (not a prefix)
    function automatic bit model_byte(input logic [7:0] b);
        int id;
        if (b == 8'hE0) begin pend_ext = 1; return 0; end
        if (b == 8'hF0) begin pend_brk = 1; return 0; end
        id     = (pend_ext ? 256 : 0) + int'(b);
        e_code = b; e_ext = pend_ext; e_brk = pend_brk; e_rep = 0;
        if (!pend_brk) begin
            if (m_down && id == held_id) e_rep = 1;
            else begin
                m_presses = (m_presses + 1) % 256;
                held_id   = id;
                m_down    = 1;
            end
        end else if (id == held_id) begin
            m_down = 0;
        end
        pend_ext = 0; pend_brk = 0;
        return 1;
    endfunction

    // One clock: sample at negedge, score any pop, then present the FIFO head.
    task automatic cycle();
        bit ev;
        logic [7:0] b;
        @(negedge clk);
        cyc++;
        if (overflow) m_ovf = 1;
        if (nextdata_n === 1'b0) begin
            check("nd_one_cycle", {31'd0, prev_ack}, 32'd0);
            if (last_ack >= 0) check("pop_spacing", cyc - last_ack, 32'd3);
            last_ack = cyc;
            prev_ack = 1;
            if (q.size() == 0) begin
                check("pop_when_empty", {31'd0, nextdata_n}, 32'd1);
            end else begin
                b  = q.pop_front();
                ev = model_byte(b);
                check("event_valid", {31'd0, event_valid}, {31'd0, ev});
                if (ev) begin
                    check("key_code", key_code, e_code);
                    check("key_ext", key_ext, e_ext);
                    check("key_break", key_break, e_brk);
                    check("key_repeat", key_repeat, e_rep);
                    check("ascii", ascii, ref_ascii(e_code, e_ext));
                end
                check("key_down", key_down, m_down);
                check("cur_code", cur_code, held_id[7:0]);
                check("press_cnt", press_cnt, m_presses);
            end
        end else begin
            check("ev_idle", {31'd0, event_valid}, 32'd0);
            prev_ack = 0;
        end
        check("ovf_seen", ovf_seen, m_ovf);
        ready = (q.size() != 0);
        data  = ready ? q[0] : 8'h00;
        if (!ready) last_ack = -1;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        ready = 1'b1;
        data  = q[0];
    endtask

    task automatic drain();
        int budget;
        budget = 3 * q.size() + 20;
        while (q.size() > 0 && budget > 0) begin
            cycle();
            budget--;
        end
        if (q.size() > 0) begin
            check("drain_timeout", q.size(), 32'd0);
            q.delete();
            ready = 1'b0;
        end
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        ready = 1'b0; data = 8'h00; overflow = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] prev, c;
        logic [7:0] pool [7] = '{8'h1C, 8'h32, 8'h21, 8'h29, 8'h5A, 8'h75, 8'h45};
        rst = 1'b1; ready = 1'b0; data = 8'h00; overflow = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_nextdata_n", nextdata_n, 1);
        check("rst_event_valid", event_valid, 0);
        check("rst_key_down", key_down, 0);
        check("rst_press_cnt", press_cnt, 0);
        check("rst_cur_code", cur_code, 0);
        check("rst_ovf_seen", ovf_seen, 0);
        check("rst_ascii", ascii, 0);
        rst = 1'b0;
        repeat (2) cycle();

        // Single make 1C: pop on the first edge, event in the same cycle as ACK
        push(SC_A);
        cycle();
        check("latency_ack", nextdata_n, 0);
        drain();
        check("t1_press_cnt", press_cnt, 1);
        check("t1_cur_code", cur_code, SC_A);

        // Typematic repeats then release
        push(SC_A); push(SC_A); push(BRK_CODE); push(SC_A);
        drain();
        check("t2_press_cnt", press_cnt, 1);
        check("t2_break", key_break, 1);
        check("t2_down", key_down, 0);

        // Extended make and both prefix orders for release
        push(EXT_CODE); push(SC_UP);
        push(EXT_CODE); push(BRK_CODE); push(SC_UP);
        push(EXT_CODE); push(SC_UP);
        push(BRK_CODE); push(EXT_CODE); push(SC_UP);
        drain();
        check("t3_ext", key_ext, 1);
        check("t3_break", key_break, 1);
        check("t3_down", key_down, 0);

        // Overflow pulse is sticky
        overflow = 1'b1;
        cycle();
        overflow = 1'b0;
        repeat (20) cycle();
        check("t4_ovf_sticky", ovf_seen, 1);

        // 256 make/break pairs of changing codes wrap the counter
        do_reset();
        prev = 8'h00;
        for (int i = 0; i < 256; i++) begin
            do c = 8'($urandom_range(1, 127)); while (c == prev);
            push(c); push(BRK_CODE); push(c);
            prev = c;
        end
        drain();
        check("t5_wrap", press_cnt, 0);

        // Random mix of prefixes and a small key pool
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0:       push(EXT_CODE);
                1:       push(BRK_CODE);
                default: push(pool[$urandom_range(0, 6)]);
            endcase
        end
        drain();

        // Reset asserted during ACK aborts the pop at once
        push(SC_A);
        cycle();
        check("t7_in_ack", nextdata_n, 0);
        #1 rst = 1'b1;
        #1;
        check("t7_nextdata_n", nextdata_n, 1);
        check("t7_event_valid", event_valid, 0);
        check("t7_press_cnt", press_cnt, 0);
        check("t7_key_down", key_down, 0);
        check("t7_key_code", key_code, 0);
        check("t7_ovf_seen", ovf_seen, 0);
        q.delete(); ready = 1'b0; data = 8'h00;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
